rl02_header_deframer: RTL and testbench

//  Consumes the decoded bit stream (bit + valid strobe) from the MFM decoder and frames RL02 sector headers:

---
 rtl/rl02_header_deframer.sv | 192 +++++++++++++++++++
 tb/tb_rl02_header_deframer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl02_header_deframer.sv
// RL02 sector header deframer.
// Takes the decoded bit stream from the MFM decoder, hunts the zero preamble,
// accepts the sync '1', shifts in the address, zero and CRC words LSB-first,
// and publishes the decoded header fields with a one-cycle hdr_valid pulse.
// A long run of '1's while hunting means the decoder locked onto the wrong
// half-bit phase, so skip_mfm_bit is pulsed to let it slip by one half-bit.
module rl02_header_deframer #(
   parameter int          PREAMBLE_MIN = 16,
   parameter int          SLIP_MIN     = 16,
   parameter logic [15:0] CRC_INIT     = 16'h0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       search_en,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       skip_mfm_bit,
   output logic       hdr_valid,
   output logic       hdr_crc_ok,
   output logic [8:0] hdr_cyl,
   output logic       hdr_head,
   output logic [5:0] hdr_sector,
   output logic       hdr_zero_ok,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HUNT,
      S_SYNC,
      S_WORD,
      S_SLIP_WAIT
   } state_t;

   localparam logic [7:0] PRE_MIN_C  = 8'(PREAMBLE_MIN);
   localparam logic [7:0] SLIP_MIN_C = 8'(SLIP_MIN);

   state_t      state_q;
   logic [7:0]  zero_cnt_q;
   logic [7:0]  one_cnt_q;
   logic [1:0]  slip_cnt_q;
   logic [5:0]  bit_cnt_q;
   logic [15:0] sr_q;
   logic [15:0] crc_q;
   logic [15:0] addr_q;
   logic        zero_ok_stage_q;

   logic        skip_q;
   logic        hdr_valid_q;
   logic        hdr_crc_ok_q;
   logic [8:0]  hdr_cyl_q;
   logic        hdr_head_q;
   logic [5:0]  hdr_sector_q;
   logic        hdr_zero_ok_q;

   logic [15:0] sr_d;
   logic [15:0] crc_d;
   logic        crc_fb;
   logic [7:0]  zero_inc;
   logic [7:0]  one_inc;

   // Next shift-register / CRC values and saturating counter increments for the current bit
   always_comb begin
      crc_fb   = crc_q[0] ^ bit_in;
      crc_d    = (crc_q >> 1) ^ (crc_fb ? 16'hA001 : 16'h0000);
      sr_d     = {bit_in, sr_q[15:1]};
      zero_inc = (zero_cnt_q == 8'hFF) ? 8'hFF : zero_cnt_q + 8'd1;
      one_inc  = (one_cnt_q == 8'hFF) ? 8'hFF : one_cnt_q + 8'd1;
   end

   // Framing state machine with registered header fields and pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         zero_cnt_q      <= 8'd0;
         one_cnt_q       <= 8'd0;
         slip_cnt_q      <= 2'd0;
         bit_cnt_q       <= 6'd0;
         sr_q            <= 16'h0000;
         crc_q           <= 16'h0000;
         addr_q          <= 16'h0000;
         zero_ok_stage_q <= 1'b0;
         skip_q          <= 1'b0;
         hdr_valid_q     <= 1'b0;
         hdr_crc_ok_q    <= 1'b0;
         hdr_cyl_q       <= 9'd0;
         hdr_head_q      <= 1'b0;
         hdr_sector_q    <= 6'd0;
         hdr_zero_ok_q   <= 1'b0;
      end else begin
         // Pulses default low; at most one cycle wide
         skip_q      <= 1'b0;
         hdr_valid_q <= 1'b0;
         if (!search_en) begin
            // Disabling the search discards any partial header, even if a bit arrives now
            state_q    <= S_IDLE;
            zero_cnt_q <= 8'd0;
            one_cnt_q  <= 8'd0;
            slip_cnt_q <= 2'd0;
            bit_cnt_q  <= 6'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q    <= S_HUNT;
                  zero_cnt_q <= 8'd0;
                  one_cnt_q  <= 8'd0;
               end
               S_HUNT: begin
                  if (bit_valid) begin
                     if (!bit_in) begin
                        zero_cnt_q <= zero_inc;
                        one_cnt_q  <= 8'd0;
                     end else if (zero_cnt_q >= PRE_MIN_C) begin
                        // Sync bit after a long enough preamble: start a fresh header
                        state_q    <= S_SYNC;
                        bit_cnt_q  <= 6'd0;
                        crc_q      <= CRC_INIT;
                        zero_cnt_q <= 8'd0;
                        one_cnt_q  <= 8'd0;
                     end else begin
                        zero_cnt_q <= 8'd0;
                        one_cnt_q  <= one_inc;
                        if (one_inc >= SLIP_MIN_C) begin
                           // Preamble decoded as ones: decoder is a half-bit off
                           skip_q     <= 1'b1;
                           state_q    <= S_SLIP_WAIT;
                           slip_cnt_q <= 2'd0;
                        end
                     end
                  end
               end
               S_SYNC, S_WORD: begin
                  // SYNC lasts one clock but still accepts a back-to-back strobe as header bit 0
                  if (bit_valid) begin
                     sr_q      <= sr_d;
                     crc_q     <= crc_d;
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                     state_q   <= S_WORD;
                     if (bit_cnt_q == 6'd15) begin
                        addr_q <= sr_d;
                     end
                     if (bit_cnt_q == 6'd31) begin
                        zero_ok_stage_q <= (sr_d == 16'h0000);
                     end
                     if (bit_cnt_q == 6'd47) begin
                        // Publish all fields together so they stay coherent until the next header
                        hdr_valid_q   <= 1'b1;
                        hdr_crc_ok_q  <= (crc_d == 16'h0000);
                        hdr_cyl_q     <= addr_q[15:7];
                        hdr_head_q    <= addr_q[6];
                        hdr_sector_q  <= addr_q[5:0];
                        hdr_zero_ok_q <= zero_ok_stage_q;
                        state_q       <= S_HUNT;
                        bit_cnt_q     <= 6'd0;
                        zero_cnt_q    <= 8'd0;
                        one_cnt_q     <= 8'd0;
                     end
                  end else if (state_q == S_SYNC) begin
                     state_q <= S_WORD;
                  end
               end
               S_SLIP_WAIT: begin
                  // Give the decoder four strobes to re-lock before hunting again
                  if (bit_valid) begin
                     if (slip_cnt_q == 2'd3) begin
                        state_q    <= S_HUNT;
                        slip_cnt_q <= 2'd0;
                        zero_cnt_q <= 8'd0;
                        one_cnt_q  <= 8'd0;
                     end else begin
                        slip_cnt_q <= slip_cnt_q + 2'd1;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign skip_mfm_bit = skip_q;
   assign hdr_valid    = hdr_valid_q;
   assign hdr_crc_ok   = hdr_crc_ok_q;
   assign hdr_cyl      = hdr_cyl_q;
   assign hdr_head     = hdr_head_q;
   assign hdr_sector   = hdr_sector_q;
   assign hdr_zero_ok  = hdr_zero_ok_q;
   assign busy         = (state_q == S_SYNC) || (state_q == S_WORD);

endmodule

// File: tb/tb_rl02_header_deframer.sv
// Testbench for rl02_header_deframer: table of headers plus hand-written
// sequences for short preamble, bit-slip, search abort and mid-header reset.
module tb_rl02_header_deframer;

   logic       clk;
   logic       rst_n;
   logic       search_en;
   logic       bit_in;
   logic       bit_valid;
   logic       skip_mfm_bit;
   logic       hdr_valid;
   logic       hdr_crc_ok;
   logic [8:0] hdr_cyl;
   logic       hdr_head;
   logic [5:0] hdr_sector;
   logic       hdr_zero_ok;
   logic       busy;

   rl02_header_deframer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .search_en    (search_en),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .skip_mfm_bit (skip_mfm_bit),
      .hdr_valid    (hdr_valid),
      .hdr_crc_ok   (hdr_crc_ok),
      .hdr_cyl      (hdr_cyl),
      .hdr_head     (hdr_head),
      .hdr_sector   (hdr_sector),
      .hdr_zero_ok  (hdr_zero_ok),
      .busy         (busy)
   );

   typedef struct {
      logic [15:0] addr;
      logic [15:0] zw;
      logic [15:0] flip;
      logic [8:0]  cyl;
      logic        head;
      logic [5:0]  sec;
      logic        zok;
      logic        cok;
   } vec_t;

   typedef struct {
      vec_t v;
      int   cyc;
   } exp_t;

   exp_t scoreboard[$];
   vec_t vecs[8];
   vec_t h1;

   int checks_total = 0;
   int checks_passed = 0;
   int cyc = 0;
   int last_cyc = 0;
   int hv_seen = 0;
   int hv_pushed = 0;
   int skip_cnt = 0;
   int skip_last_cyc = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end else begin
         checks_passed++;
      end
   endtask

   function automatic logic [15:0] crc16(input logic [31:0] d);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 0; i < 32; i++) begin
         fb = c[0] ^ d[i];
         c  = (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
      end
      return c;
   endfunction

   function automatic logic [47:0] frame_of(input vec_t v);
      return {crc16({v.zw, v.addr}) ^ v.flip, v.zw, v.addr};
   endfunction

   // Output monitor: pops the scoreboard on every hdr_valid and tracks skip pulses
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (hdr_valid === 1'b1) begin
            hv_seen++;
            chk("hdr_valid_expected", 32'(scoreboard.size() != 0), 32'd1);
            if (scoreboard.size() != 0) begin
               exp_t e;
               e = scoreboard.pop_front();
               $display("hdr addr=%04h zw=%04h flip=%04h: cyl=%0d head=%0d sec=%0d zok=%0d cok=%0d",
                        e.v.addr, e.v.zw, e.v.flip, hdr_cyl, hdr_head, hdr_sector, hdr_zero_ok, hdr_crc_ok);
               chk("hdr_cyl", 32'(hdr_cyl), 32'(e.v.cyl));
               chk("hdr_head", 32'(hdr_head), 32'(e.v.head));
               chk("hdr_sector", 32'(hdr_sector), 32'(e.v.sec));
               chk("hdr_zero_ok", 32'(hdr_zero_ok), 32'(e.v.zok));
               chk("hdr_crc_ok", 32'(hdr_crc_ok), 32'(e.v.cok));
               chk("hdr_latency", 32'(cyc), 32'(e.cyc));
            end
         end
         if (skip_mfm_bit === 1'b1) begin
            skip_cnt++;
            skip_last_cyc = cyc;
            chk("skip_not_busy", 32'(busy), 32'd0);
         end
      end
   end

   task automatic drive_bit(input logic b, input bit gap);
      @(negedge clk);
      bit_in    = b;
      bit_valid = 1'b1;
      last_cyc  = cyc;
      if (gap && ($urandom_range(0, 3) == 0)) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bit_valid = 1'b0;
      end
   endtask

   // Preamble, sync and header bits 0..nbits-1
   task automatic send_prefix(input vec_t v, input int pre, input int nbits, input bit gap);
      logic [47:0] f;
      f = frame_of(v);
      for (int i = 0; i < pre; i++) drive_bit(1'b0, gap);
      drive_bit(1'b1, gap);
      for (int i = 0; i < nbits; i++) drive_bit(f[i], gap);
   endtask

   task automatic send_header(input vec_t v, input int pre, input bit gap);
      logic [47:0] f;
      exp_t        e;
      f = frame_of(v);
      send_prefix(v, pre, 47, gap);
      drive_bit(f[47], 1'b0);
      e.v   = v;
      e.cyc = last_cyc + 1;
      scoreboard.push_back(e);
      hv_pushed++;
      idle(3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp1;
      int exp2;
      logic [47:0] f1;

      //           addr      zw        flip      cyl   head sec  zok  cok
      vecs[0] = '{16'h0A45, 16'h0000, 16'h0000, 9'd20, 1'b1, 6'd5, 1'b1, 1'b1};
      vecs[1] = '{16'h0A45, 16'h0000, 16'h0008, 9'd20, 1'b1, 6'd5, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'h0000, 9'd511, 1'b1, 6'd63, 1'b1, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 9'd0,   1'b0, 6'd0, 1'b1, 1'b1};
      vecs[4] = '{16'h8180, 16'h0000, 16'h0000, 9'd259, 1'b0, 6'd0, 1'b1, 1'b1};
      vecs[5] = '{16'h003F, 16'h0001, 16'h0000, 9'd0,   1'b0, 6'd63, 1'b0, 1'b1};
      vecs[6] = '{16'h0040, 16'h8000, 16'h8000, 9'd0,   1'b1, 6'd0, 1'b0, 1'b0};
      vecs[7] = '{16'h1234, 16'h0000, 16'h0000, 9'd36,  1'b0, 6'd52, 1'b1, 1'b1};
      h1 = vecs[0];

      rst_n     = 1'b0;
      search_en = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({skip_mfm_bit, hdr_valid, hdr_crc_ok, hdr_cyl, hdr_head,
                                hdr_sector, hdr_zero_ok, busy}), 32'd0);
      rst_n = 1'b1;
      search_en = 1'b1;
      idle(3);

      // Table of headers, alternating back-to-back and gapped strobes
      for (int i = 0; i < 8; i++) begin
         send_header(vecs[i], 20, (i % 2) == 1);
      end

      // Short preamble, then a full header
      for (int i = 0; i < 10; i++) drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      send_header(h1, 20, 1'b0);

      // Bit slip: 16 ones -> one skip; next 4 strobes ignored; 15 more ones do not skip, the 16th does
      for (int i = 0; i < 16; i++) drive_bit(1'b1, 1'b0);
      exp1 = last_cyc + 1;
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
      for (int i = 0; i < 15; i++) drive_bit(1'b1, 1'b0);
      idle(2);
      chk("skip_count_first", 32'(skip_cnt), 32'd1);
      chk("skip_cycle_first", 32'(skip_last_cyc), 32'(exp1));
      drive_bit(1'b1, 1'b0);
      exp2 = last_cyc + 1;
      idle(2);
      chk("skip_count_second", 32'(skip_cnt), 32'd2);
      chk("skip_cycle_second", 32'(skip_last_cyc), 32'(exp2));
      for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
      send_header(h1, 20, 1'b0);

      // Previous header is vecs-free h1; prime a distinct header so held fields are distinguishable
      send_header(vecs[7], 20, 1'b0);

      // Search abort at header bit 30 (strobe in the same cycle is ignored)
      f1 = frame_of(h1);
      send_prefix(h1, 20, 30, 1'b0);
      @(negedge clk);
      chk("busy_mid_header", 32'(busy), 32'd1);
      search_en = 1'b0;
      bit_in    = f1[30];
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      chk("busy_after_abort", 32'(busy), 32'd0);
      idle(3);
      chk("fields_held_after_abort", 32'({hdr_cyl, hdr_head, hdr_sector}),
          32'({9'd36, 1'b0, 6'd52}));
      search_en = 1'b1;
      idle(2);
      send_header(h1, 20, 1'b0);

      // Reset at header bit 40 with strobes every cycle
      send_prefix(h1, 20, 40, 1'b0);
      @(negedge clk);
      rst_n     = 1'b0;
      bit_in    = f1[40];
      bit_valid = 1'b1;
      @(negedge clk);
      bit_in    = f1[41];
      chk("outputs_after_midreset", 32'({skip_mfm_bit, hdr_valid, hdr_crc_ok, hdr_cyl, hdr_head,
                                         hdr_sector, hdr_zero_ok, busy}), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      bit_valid = 1'b0;
      idle(3);
      send_header(h1, 20, 1'b0);

      idle(5);
      chk("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
      chk("hdr_valid_count", 32'(hv_seen), 32'(hv_pushed));
      chk("skip_total", 32'(skip_cnt), 32'd2);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
